// File: rtl/insn_fetch_decode.sv
// -----------------------------------------------------------------------------
// insn_fetch_decode
//
// Front end of the core: fetches one 32-bit instruction at a time from
// instruction memory, decodes it, reads operands from the 32-entry register
// file, presents the decoded fields to the execution unit for exactly one
// cycle and writes the execution result back into the register file.
//
// Instruction flow (one instruction in flight):
//   FETCH_REQ -> FETCH_WAIT -> DECODE -> ISSUE -> FETCH_REQ
//   DECODE of an unsupported opcode -> HALT (left only by rst)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   imem_req_valid/ready fetch request handshake, imem_addr = current PC
//   imem_rsp_valid/data  instruction response (only taken in FETCH_WAIT)
//   issue_valid          one-cycle pulse qualifying the decoded outputs
//   opcode/funct3/funct7 decoded instruction fields
//   imm                  raw insn[31:12]
//   rs1/rs2              operand values x[insn[19:15]] / x[insn[24:20]]
//   rd_enable_write, rd  execution result for writeback during ISSUE
//   illegal              sticky unsupported-opcode flag
//   dbg_idx, dbg_data    combinational debug read of the register file
//   retired              retired-instruction count
//
// Build option:
//   RETIRE_COUNTER_EN    when defined, `retired` is a 32-bit wrapping counter
//                        of issued instructions; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module insn_fetch_decode #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            issue_valid,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [19:0]     imm,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   input  logic            rd_enable_write,
   input  logic [XLEN-1:0] rd,
   output logic            illegal,
   input  logic [4:0]      dbg_idx,
   output logic [XLEN-1:0] dbg_data,
   output logic [31:0]     retired
);

   localparam logic [6:0]      OP_LUI  = 7'b0110111;
   localparam logic [6:0]      OP_REG  = 7'b0110011;
   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

   typedef enum logic [2:0] {
      ST_FETCH_REQ  = 3'd0,
      ST_FETCH_WAIT = 3'd1,
      ST_DECODE     = 3'd2,
      ST_ISSUE      = 3'd3,
      ST_HALT       = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [XLEN-1:0]   pc_r;
   logic [31:0]       insn_r;
   logic [4:0]        rd_idx_r;
   logic [XLEN-1:0]   regs_r [32];
   logic              imem_req_valid_r;
   logic              issue_valid_r;
   logic              illegal_r;
   logic [6:0]        opcode_r;
   logic [2:0]        funct3_r;
   logic [6:0]        funct7_r;
   logic [19:0]       imm_r;
   logic [XLEN-1:0]   rs1_r;
   logic [XLEN-1:0]   rs2_r;
   logic              legal_s;
   logic              write_en_s;

   // Only LUI and register-register ALU instructions are executed.
   function automatic logic is_legal_opcode(input logic [6:0] op);
      return (op == OP_LUI) || (op == OP_REG);
   endfunction

   // Register read with x0 hard-wired to zero.
   function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx,
                                                input logic [XLEN-1:0] val);
      return (idx == 5'd0) ? {XLEN{1'b0}} : val;
   endfunction

   assign legal_s    = is_legal_opcode(insn_r[6:0]);
   // Writeback only happens in ISSUE, so it never collides with the DECODE read.
   assign write_en_s = (state_r == ST_ISSUE) && rd_enable_write && (rd_idx_r != 5'd0);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FETCH_REQ;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH_REQ: begin
            if (imem_req_ready) begin
               state_next_s = ST_FETCH_WAIT;
            end else begin
               state_next_s = ST_FETCH_REQ;
            end
         end
         ST_FETCH_WAIT: begin
            if (imem_rsp_valid) begin
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH_WAIT;
            end
         end
         ST_DECODE: begin
            if (legal_s) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_HALT;
            end
         end
         ST_ISSUE: state_next_s = ST_FETCH_REQ;
         ST_HALT:  state_next_s = ST_HALT;
         default:  state_next_s = ST_FETCH_REQ;
      endcase
   end

   // Control outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_req_valid_r <= 1'b1;
         issue_valid_r    <= 1'b0;
         illegal_r        <= 1'b0;
      end else begin
         imem_req_valid_r <= (state_next_s == ST_FETCH_REQ);
         issue_valid_r    <= (state_next_s == ST_ISSUE);
         if ((state_r == ST_DECODE) && !legal_s) begin
            illegal_r <= 1'b1;
         end else begin
            illegal_r <= illegal_r;
         end
      end
   end

   // Program counter: advances once per issued instruction, wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (state_r == ST_ISSUE) begin
         pc_r <= pc_r + PC_STEP;
      end else begin
         pc_r <= pc_r;
      end
   end

   // Instruction latch: responses outside FETCH_WAIT are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         insn_r <= 32'd0;
      end else if ((state_r == ST_FETCH_WAIT) && imem_rsp_valid) begin
         insn_r <= imem_rsp_data;
      end else begin
         insn_r <= insn_r;
      end
   end

   // Decoded fields and operands; held between issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         opcode_r <= 7'd0;
         funct3_r <= 3'd0;
         funct7_r <= 7'd0;
         imm_r    <= 20'd0;
         rs1_r    <= {XLEN{1'b0}};
         rs2_r    <= {XLEN{1'b0}};
         rd_idx_r <= 5'd0;
      end else if (state_r == ST_DECODE) begin
         opcode_r <= insn_r[6:0];
         funct3_r <= insn_r[14:12];
         funct7_r <= insn_r[31:25];
         imm_r    <= insn_r[31:12];
         rs1_r    <= read_reg(insn_r[19:15], regs_r[insn_r[19:15]]);
         rs2_r    <= read_reg(insn_r[24:20], regs_r[insn_r[24:20]]);
         rd_idx_r <= insn_r[11:7];
      end else begin
         opcode_r <= opcode_r;
         funct3_r <= funct3_r;
         funct7_r <= funct7_r;
         imm_r    <= imm_r;
         rs1_r    <= rs1_r;
         rs2_r    <= rs2_r;
         rd_idx_r <= rd_idx_r;
      end
   end

   // Register file: cleared on reset, written back during ISSUE (never x0).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (write_en_s) begin
         regs_r[rd_idx_r] <= rd;
      end else begin
         regs_r[rd_idx_r] <= regs_r[rd_idx_r];
      end
   end

`ifdef RETIRE_COUNTER_EN
   logic [31:0] retired_r;

   // Retired-instruction counter: one per ISSUE cycle, illegal ones never issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_r <= 32'd0;
      end else if (state_r == ST_ISSUE) begin
         retired_r <= retired_r + 32'd1;
      end else begin
         retired_r <= retired_r;
      end
   end

   assign retired = retired_r;
`else
   assign retired = 32'd0;
`endif

   assign imem_req_valid = imem_req_valid_r;
   assign imem_addr      = pc_r;
   assign issue_valid    = issue_valid_r;
   assign illegal        = illegal_r;
   assign opcode         = opcode_r;
   assign funct3         = funct3_r;
   assign funct7         = funct7_r;
   assign imm            = imm_r;
   assign rs1            = rs1_r;
   assign rs2            = rs2_r;
   assign dbg_data       = read_reg(dbg_idx, regs_r[dbg_idx]);

endmodule

// File: tb/tb_insn_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_insn_fetch_decode
//
// Drives insn_fetch_decode with a behavioural instruction memory and a
// combinational model of the execution unit (LUI: rd = zero-extended imm;
// OP: add, or sub when funct7[5] is set). A table of instructions with
// handshake delays and expected destination values is applied in a loop;
// decoded fields are checked through a scoreboard queue. Hand-written
// sequences cover reset during FETCH_WAIT and the illegal-opcode halt.
// -----------------------------------------------------------------------------
module tb_insn_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        issue_valid;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [19:0] imm;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        rd_enable_write;
   logic [31:0] rd;
   logic        illegal;
   logic [4:0]  dbg_idx = 5'd0;
   logic [31:0] dbg_data;
   logic [31:0] retired;

   insn_fetch_decode #(.XLEN(32), .RESET_PC(32'd0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .issue_valid(issue_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .imm(imm), .rs1(rs1), .rs2(rs2),
      .rd_enable_write(rd_enable_write), .rd(rd), .illegal(illegal),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] insn;
      int          rdy_dly;
      int          rsp_dly;
      bit          spurious;
      bit          wen;
      bit          legal;
      logic [4:0]  dst;
      logic [31:0] dst_val;
   } row_t;

   typedef struct {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [19:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } exp_issue_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   exp_issue_t  sb_q[$];
   exp_issue_t  mon_e;
   logic [31:0] shadow [32];
   logic [31:0] exp_pc = 32'd0;
   logic [31:0] exp_retired = 32'd0;
   bit          cur_wen = 1'b1;
   row_t        tbl [10];
   row_t        hand;

   // Execution-unit model, responding in the issue cycle.
   always_comb begin
      rd_enable_write = issue_valid & cur_wen;
      rd = 32'd0;
      if (opcode == 7'b0110111) rd = {12'd0, imm};
      else if (funct7[5])       rd = rs1 - rs2;
      else                      rd = rs1 + rs2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every issue pulse pops and compares one expected record.
   always @(negedge clk) begin
      if (issue_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("opcode", {25'd0, opcode}, {25'd0, mon_e.opcode});
            check("funct3", {29'd0, funct3}, {29'd0, mon_e.funct3});
            check("funct7", {25'd0, funct7}, {25'd0, mon_e.funct7});
            check("imm",    {12'd0, imm},    {12'd0, mon_e.imm});
            check("rs1",    rs1,             mon_e.rs1);
            check("rs2",    rs2,             mon_e.rs2);
         end
      end
   end

   task automatic check_retired();
`ifdef RETIRE_COUNTER_EN
      check("retired", retired, exp_retired);
`else
      check("retired", retired, 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_pc = 32'd0;
      exp_retired = 32'd0;
      for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
   endtask

   // One fetch/decode/issue transaction; entered and left at a negedge in FETCH_REQ.
   task automatic run_insn(input row_t r);
      exp_issue_t e;
      cur_wen = r.wen;
      check("req_valid_idle", {31'd0, imem_req_valid}, 32'd1);
      check("imem_addr", imem_addr, exp_pc);
      for (int i = 0; i < r.rdy_dly; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = r.spurious;
         imem_rsp_data  = 32'h0000_0013;
         @(negedge clk);
         check("req_valid_stall", {31'd0, imem_req_valid}, 32'd1);
         check("addr_stall", imem_addr, exp_pc);
         check("issue_stall", {31'd0, issue_valid}, 32'd0);
      end
      imem_req_ready = 1'b1;
      imem_rsp_valid = r.spurious;
      imem_rsp_data  = 32'h0000_0013;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      check("req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
      for (int i = 0; i < r.rsp_dly; i++) begin
         @(negedge clk);
         check("req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
         check("issue_early", {31'd0, issue_valid}, 32'd0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.insn;
      if (r.legal) begin
         e.opcode = r.insn[6:0];
         e.funct3 = r.insn[14:12];
         e.funct7 = r.insn[31:25];
         e.imm    = r.insn[31:12];
         e.rs1    = shadow[r.insn[19:15]];
         e.rs2    = shadow[r.insn[24:20]];
         sb_q.push_back(e);
      end
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      check("issue_in_decode", {31'd0, issue_valid}, 32'd0);
      @(negedge clk);
      if (r.legal) begin
         check("issue_pulse", {31'd0, issue_valid}, 32'd1);
         @(negedge clk);
         check("issue_one_cycle", {31'd0, issue_valid}, 32'd0);
         exp_pc = exp_pc + 32'd4;
         exp_retired = exp_retired + 32'd1;
         if (r.wen && r.dst != 5'd0) shadow[r.dst] = r.dst_val;
         dbg_idx = r.dst;
         #1;
         check("reg_writeback", dbg_data, r.dst_val);
         check("next_addr", imem_addr, exp_pc);
         check_retired();
      end else begin
         check("illegal_flag", {31'd0, illegal}, 32'd1);
         check("issue_illegal", {31'd0, issue_valid}, 32'd0);
         check("req_after_illegal", {31'd0, imem_req_valid}, 32'd0);
      end
   endtask

   initial begin
      tbl[0] = '{32'h123450B7, 0, 0, 1'b0, 1'b1, 1'b1, 5'd1,  32'h00012345};
      tbl[1] = '{32'h00001137, 0, 0, 1'b0, 1'b1, 1'b1, 5'd2,  32'h00000001};
      tbl[2] = '{32'h002081B3, 0, 0, 1'b0, 1'b1, 1'b1, 5'd3,  32'h00012346};
      tbl[3] = '{32'h40208233, 5, 0, 1'b0, 1'b1, 1'b1, 5'd4,  32'h00012344};
      tbl[4] = '{32'h00108033, 0, 3, 1'b1, 1'b1, 1'b1, 5'd0,  32'h00000000};
      tbl[5] = '{32'h40110333, 0, 0, 1'b0, 1'b1, 1'b1, 5'd6,  32'hFFFEDCBC};
      tbl[6] = '{32'hABCDE3B7, 0, 1, 1'b0, 1'b0, 1'b1, 5'd7,  32'h00000000};
      tbl[7] = '{32'h00300433, 1, 0, 1'b0, 1'b1, 1'b1, 5'd8,  32'h00012346};
      tbl[8] = '{32'hFFFFFFB7, 2, 1, 1'b1, 1'b1, 1'b1, 5'd31, 32'h000FFFFF};
      tbl[9] = '{32'h00000013, 0, 0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00000000};

      // Power-on reset and reset-state checks.
      @(negedge clk);
      do_reset();
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_issue", {31'd0, issue_valid}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_opcode", {25'd0, opcode}, 32'd0);
      check("rst_imm", {12'd0, imm}, 32'd0);
      check("rst_rs1", rs1, 32'd0);
      check_retired();
      for (int i = 0; i < 32; i++) begin
         dbg_idx = 5'(i);
         #1;
         check("rst_reg", dbg_data, 32'd0);
      end

      // Legal instruction table, including stalls and spurious responses.
      for (int i = 0; i < 9; i++) begin
         run_insn(tbl[i]);
         if (i == 2) check_retired();
      end
      dbg_idx = 5'd0;
      #1;
      check("x0_reads_zero", dbg_data, 32'd0);

      // Reset while waiting for a response, with a response offered afterwards.
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("mid_wait", {31'd0, imem_req_valid}, 32'd0);
      do_reset();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0013;
      @(negedge clk);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      check("post_rst_illegal", {31'd0, illegal}, 32'd0);
      check("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
      check("post_rst_addr", imem_addr, 32'd0);
      check_retired();
      for (int i = 1; i < 32; i++) begin
         dbg_idx = 5'(i);
         #1;
         check("post_rst_reg", dbg_data, 32'd0);
      end
      hand = tbl[0];
      run_insn(hand);

      // Illegal opcode halts the front end until reset.
      run_insn(tbl[9]);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
         check("halt_no_issue", {31'd0, issue_valid}, 32'd0);
      end
      check("halt_illegal_sticky", {31'd0, illegal}, 32'd1);
      check_retired();
      do_reset();
      check("halt_rst_illegal", {31'd0, illegal}, 32'd0);
      check("halt_rst_req", {31'd0, imem_req_valid}, 32'd1);
      check("halt_rst_addr", imem_addr, 32'd0);
      hand = tbl[1];
      run_insn(hand);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/insn_fetch_decode.md
Name: insn_fetch_decode

Overview:
Front end of the core. Fetches 32-bit instructions from instruction memory over a valid/ready request and valid response interface. Decodes each instruction and reads the register file. Presents opcode, funct3, funct7, imm and operand values to the execution unit (insn_exec), then writes its rd result back into the register file. Owns the PC and the 32-entry register file; one instruction is in flight at a time.

Parameters:
XLEN, 32, register and PC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address (current PC)
imem_rsp_valid  input  1  instruction data valid
imem_rsp_data  input  32  instruction word
issue_valid  output  1  decoded fields valid, one-cycle pulse
opcode  output  7  insn[6:0]
funct3  output  3  insn[14:12]
funct7  output  7  insn[31:25]
imm  output  20  insn[31:12], raw
rs1  output  XLEN  value of x[insn[19:15]]
rs2  output  XLEN  value of x[insn[24:20]]
rd_enable_write  input  1  exec result valid for writeback
rd  input  XLEN  exec result
illegal  output  1  sticky: unsupported opcode decoded
dbg_idx  input  5  debug register index
dbg_data  output  XLEN  combinational read of x[dbg_idx]
retired  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`. Synchronous active-high `rst` applies in any state on the next edge.
- Reset state:
  - state=FETCH_REQ, pc=RESET_PC.
  - All 32 registers = 0.
  - All outputs = 0, except imem_req_valid=1 and imem_addr=RESET_PC from the first post-reset cycle.
- FETCH_REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready is high → FETCH_WAIT; otherwise stay. Address is held stable while waiting.
- FETCH_WAIT: imem_req_valid=0. On imem_rsp_valid, latch imem_rsp_data → DECODE.
  - imem_rsp_valid outside FETCH_WAIT is ignored, including a response arriving in the acceptance cycle.
  - Memory must respond at least 1 cycle after acceptance.
- DECODE:
  - Register outputs: opcode, funct3, funct7, imm, and rs1/rs2 read from the register file.
  - Latch internal rd_idx = insn[11:7].
  - Legal opcodes: 7'b0110111 and 7'b0110011 → ISSUE. Any other opcode → illegal=1, → HALT.
- ISSUE:
  - issue_valid=1 for exactly this cycle; exec is combinational and responds in the same cycle.
  - At the clock edge, if rd_enable_write && rd_idx!=0, write x[rd_idx]=rd.
  - pc = pc+4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
  - → FETCH_REQ.
- HALT: no requests, issue_valid=0. Only rst leaves HALT.
- Register x0:
  - Reads always return 0; writes to x0 are dropped.
  - dbg_data for index 0 = 0.
- Output hold: decoded outputs hold their last values between issues. Consumers qualify them with issue_valid only.
- Throughput: minimum 4 cycles per instruction, with ready and response each arriving in the first possible cycle.
- No read/write hazard: writeback (ISSUE) and operand read (DECODE) never share a cycle, so no forwarding is needed.
- Reset mid-operation: in FETCH_WAIT, any later response is ignored until the new FETCH_REQ is accepted. The memory must not return a stale response after reset; this is the bench's responsibility.

Optional Feature:
RETIRE_COUNTER_EN
- With the macro: `retired` resets to 0 and increments by 1 at the end of each ISSUE cycle, wrapping at 2^32. Illegal instructions do not count.
- Without the macro: `retired` is tied to 0 and no counter flops are built.

Test Plan:
- Reset then hold imem_req_ready=1 → first request imem_addr=RESET_PC (0); all dbg_data reads return 0; illegal=0.
- Fetch 0x123450B7 (lui x1), 0x00001137 (lui x2), 0x002081B3 (add x3,x1,x2), with insn_exec attached:
  - x1=0x00012345, x2=0x00000001, x3=0x00012346.
  - imem_addr sequence 0, 4, 8, 0xC.
  - issue_valid exactly one cycle per instruction.
  - retired=3 with RETIRE_COUNTER_EN.
- After the above, 0x40208233 (sub x4,x1,x2) → x4=0x00012344. Then 0x00108033 (add x0,x1,x1) → x0 still reads 0.
- Hold imem_req_ready=0 for 5 cycles → imem_req_valid=1 and imem_addr held constant throughout; no issue_valid.
- Delay the response by 3 cycles → no early issue. A spurious imem_rsp_valid in FETCH_REQ is ignored.
- Fetch 0x00000013 (opcode 0010011) → illegal=1, no issue_valid, no further requests for 20 cycles. Assert rst → illegal=0, refetch at RESET_PC.
- Assert rst during FETCH_WAIT → next request at RESET_PC; x1..x31 read 0.
